// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB4 master port
// between NREQ requesters. Optional macro: APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_wdata,
   input  logic [NREQ*4-1:0] req_strb,
   input  logic [NREQ*3-1:0] req_prot,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_slverr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [31:0]       paddr,
   output logic [31:0]       pwdata,
   output logic [3:0]        pstrb,
   output logic [2:0]        pprot,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   gnt_q;
   logic [IW-1:0]   gnt_d;
   logic [IW:0]     idx_s;
   logic            hit;
   logic            tmo;

   logic            psel_q, penable_q, pwrite_q;
   logic [31:0]     paddr_q, pwdata_q;
   logic [3:0]      pstrb_q;
   logic [2:0]      pprot_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [31:0]     rsp_rdata_q;
   logic            rsp_slverr_q;

   logic            sel_write;
   logic [31:0]     sel_addr, sel_wdata;
   logic [3:0]      sel_strb;
   logic [2:0]      sel_prot;

   // Round-robin pick: first valid index at or after the pointer, wrapping.
   always_comb begin
      gnt_d = ptr_q;
      hit   = 1'b0;
      idx_s = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_s = {1'b0, ptr_q} + (IW+1)'(k);
         if (idx_s >= (IW+1)'(NREQ))
            idx_s = idx_s - (IW+1)'(NREQ);
         if (req_valid[idx_s[IW-1:0]]) begin
            gnt_d = idx_s[IW-1:0];
            hit   = 1'b1;
         end
      end
   end

   // Mux the candidate requester's transfer fields.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_strb  = '0;
      sel_prot  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_d == IW'(i)) begin
            sel_write = req_write[i];
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
            sel_strb  = req_strb[4*i +: 4];
            sel_prot  = req_prot[3*i +: 3];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE && hit) ?
                      (NREQ'(1) << gnt_d) : '0;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tcnt_q;
   // Abandon when this wait cycle would bring the count to the limit.
   assign tmo = (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   // No limit: ACCESS waits for pready indefinitely.
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   // Transfer sequencer: IDLE -> SETUP -> ACCESS, registered APB/response.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         pprot_q      <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         tcnt_q       <= '0;
`endif
      end else begin
         rsp_valid_q <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  state_q  <= S_SETUP;
                  gnt_q    <= gnt_d;
                  ptr_q    <= (gnt_d == IW'(NREQ - 1)) ? '0 : gnt_d + 1'b1;
                  psel_q   <= 1'b1;
                  pwrite_q <= sel_write;
                  paddr_q  <= sel_addr;
                  pwdata_q <= sel_write ? sel_wdata : '0;
                  pstrb_q  <= sel_write ? sel_strb : '0;
                  pprot_q  <= sel_prot;
               end
            end
            S_SETUP: begin
               state_q   <= S_ACCESS;
               penable_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               tcnt_q    <= '0;
`endif
            end
            S_ACCESS: begin
               if (pready) begin
                  state_q      <= S_IDLE;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  rsp_valid_q  <= NREQ'(1) << gnt_q;
                  rsp_rdata_q  <= pwrite_q ? '0 : prdata;
                  rsp_slverr_q <= pslverr;
               end else if (tmo) begin
                  state_q      <= S_IDLE;
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  rsp_valid_q  <= NREQ'(1) << gnt_q;
                  rsp_rdata_q  <= '0;
                  rsp_slverr_q <= 1'b1;
               end else begin
`ifdef APB_ARB_TIMEOUT_EN
                  tcnt_q <= tcnt_q + 1'b1;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
   assign pprot      = pprot_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized requesters and APB slave with a
// scoreboard-driven response monitor.
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;
`ifdef APB_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic            pclk = 1'b0;
   logic            preset;
   logic [N-1:0]    req_valid, req_ready, req_write;
   logic [N*32-1:0] req_addr, req_wdata;
   logic [N*4-1:0]  req_strb;
   logic [N*3-1:0]  req_prot;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_rdata;
   logic            rsp_slverr;
   logic            psel, penable, pwrite;
   logic [31:0]     paddr, pwdata, prdata;
   logic [3:0]      pstrb;
   logic [2:0]      pprot;
   logic            pready, pslverr;

   apb_req_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .preset(preset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb),
      .req_prot(req_prot), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pprot(pprot), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int          g;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] rdata;
      logic        err;
   } xfer_t;

   rsp_t  sb_q[$];
   xfer_t slv_q[$];

   int n_chk   = 0;
   int n_fail  = 0;
   int ptr     = 0;
   int free_at = 0;
   int force_w = -1;
   bit hold    = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // One requester-side cycle: drive, predict acceptance, record expectations.
   task automatic step(input logic [N-1:0] v, input bit rst);
      int            g;
      xfer_t         x;
      rsp_t          r;
      logic [N-1:0]  exp_rdy;
      preset    = rst;
      req_valid = v;
      if (!hold) begin
         for (int i = 0; i < N; i++) begin
            req_write[i]       = 1'($urandom);
            req_addr[32*i+:32] = $urandom;
            req_wdata[32*i+:32] = $urandom;
            req_strb[4*i+:4]   = 4'($urandom);
            req_prot[3*i+:3]   = 3'($urandom);
         end
      end
      #1;
      exp_rdy = '0;
      g = -1;
      if (cyc >= free_at && v != 0) begin
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
         exp_rdy[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (rst) begin
         sb_q.delete();
         slv_q.delete();
         ptr     = 0;
         free_at = cyc + 1;
      end else if (g >= 0) begin
         x.wr    = req_write[g];
         x.addr  = req_addr[32*g+:32];
         x.wdata = x.wr ? req_wdata[32*g+:32] : 32'h0;
         x.strb  = x.wr ? req_strb[4*g+:4] : 4'h0;
         x.prot  = req_prot[3*g+:3];
         if (force_w >= 0)
            x.waits = force_w;
         else if ($urandom_range(11) == 0)
            x.waits = 20;
         else
            x.waits = $urandom_range(3);
         x.rdata = $urandom;
         x.err   = ($urandom_range(3) == 0);
         r.g     = g;
         if (TMO_EN && x.waits >= TO) begin
            r.rdata = 32'h0;
            r.err   = 1'b1;
            r.due   = cyc + 2 + TO;
         end else begin
            r.rdata = x.wr ? 32'h0 : x.rdata;
            r.err   = x.err;
            r.due   = cyc + 3 + x.waits;
         end
         free_at = r.due;
         ptr     = (g + 1) % N;
         slv_q.push_back(x);
         sb_q.push_back(r);
      end
      @(negedge pclk);
   endtask

   task automatic chk_fields(input string tag, input xfer_t c);
      chk({tag, "_addr_wdata"}, {paddr, pwdata}, {c.addr, c.wdata});
      chk({tag, "_ctrl"}, 64'({pwrite, pstrb, pprot}),
          64'({c.wr, c.strb, c.prot}));
   endtask

   // APB slave: wait states and read data come from the transfer record.
   initial begin : slave
      xfer_t cur;
      int    acc;
      bit    have;
      have    = 1'b0;
      acc     = 0;
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      forever begin
         @(negedge pclk);
         if (psel && !penable) begin
            pready = 1'b0;
            if (slv_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL setup_unexpected: psel with no accepted transfer");
               have = 1'b0;
            end else begin
               cur  = slv_q.pop_front();
               have = 1'b1;
               acc  = 0;
               chk_fields("setup", cur);
            end
         end else if (psel && penable && have) begin
            chk_fields("access", cur);
            pready  = (acc == cur.waits);
            prdata  = pready ? cur.rdata : $urandom;
            pslverr = pready ? cur.err : 1'($urandom);
            acc++;
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            have    = 1'b0;
         end
      end
   end

   // Response monitor: every pulse must match the oldest expectation.
   initial begin : monitor
      rsp_t         r;
      logic [N-1:0] oh;
      forever begin
         @(negedge pclk);
         if (rsp_valid != 0) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rsp_unexpected: rsp_valid %b, none expected",
                        rsp_valid);
            end else begin
               r  = sb_q.pop_front();
               oh = '0;
               oh[r.g] = 1'b1;
               chk("rsp_valid", 64'(rsp_valid), 64'(oh));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
               chk("rsp_slverr", 64'(rsp_slverr), 64'(r.err));
               chk("rsp_cycle", 64'(cyc), 64'(r.due));
            end
         end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_missing: no pulse, expected req %0d at cycle %0d",
                     sb_q[0].g, sb_q[0].due);
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      preset    = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      @(negedge pclk);
      repeat (3) step('0, 1'b1);
      chk("rst_apb", 64'({psel, penable, pwrite, pstrb, pprot}), 64'h0);
      chk("rst_addr", {paddr, pwdata}, 64'h0);
      chk("rst_rsp", 64'({rsp_valid, rsp_slverr, rsp_rdata}), 64'h0);

      // Directed zero-wait write from requester 2.
      hold = 1'b1;
      req_write[2]      = 1'b1;
      req_addr[64+:32]  = 32'h0000_1004;
      req_wdata[64+:32] = 32'hDEAD_BEEF;
      req_strb[8+:4]    = 4'hF;
      force_w = 0;
      step(4'b0100, 1'b0);
      // Directed read from requester 0 with three wait states.
      req_write[0]      = 1'b0;
      req_addr[0+:32]   = 32'h20;
      force_w = 3;
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0001, 1'b0);
      repeat (8) step(4'b0000, 1'b0);
      hold    = 1'b0;
      force_w = -1;

      // Random traffic.
      for (int t = 0; t < 300; t++)
         step(($urandom_range(4) == 0) ? '0 : N'($urandom), 1'b0);
      // Everyone requesting: strict rotation.
      repeat (40) step('1, 1'b0);
      repeat (25) step('0, 1'b0);

      // Reset while stalled in ACCESS, then check pointer restart.
      force_w = 10;
      step(4'b0100, 1'b0);
      force_w = -1;
      step('0, 1'b0);
      step('0, 1'b0);
      step('0, 1'b1);
      chk("abort_psel", 64'({psel, penable}), 64'h0);
      step(4'b1010, 1'b0);
      repeat (30) step('0, 1'b0);

      chk("sb_drained", 64'(sb_q.size()), 64'h0);
      chk("slave_drained", 64'(slv_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
